// File: rtl/barcodescanner_nios_altmemddr_0_ex_pattern_sched_pkg.sv
// Shared types and widths for the memory-test pattern scheduler.
package barcodescanner_nios_altmemddr_0_ex_pattern_sched_pkg;

    localparam int LFSR_W = 8;
    localparam int ERR_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_RESEED = 3'd2,
        S_READ   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/barcodescanner_nios_altmemddr_0_ex_lfsr8.sv
// 8-bit pattern LFSR: enable low reseeds, load takes ldata, pause holds.
module barcodescanner_nios_altmemddr_0_ex_lfsr8
    import barcodescanner_nios_altmemddr_0_ex_pattern_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'd32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              pause,
    input  logic              load,
    input  logic [LFSR_W-1:0] ldata,
    output logic [LFSR_W-1:0] data
);

    logic [LFSR_W-1:0] data_q;

    // Rotate left, with the outgoing bit 7 also folded into bits 2, 3 and 4.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            data_q <= SEED;
        else if (!enable)
            data_q <= SEED;
        else if (load)
            data_q <= ldata;
        else if (!pause)
            data_q <= {data_q[6:0], data_q[7]}
                    ^ {3'b000, data_q[7], data_q[7], data_q[7], 2'b00};
    end

    assign data = data_q;

endmodule

// File: rtl/barcodescanner_nios_altmemddr_0_ex_pattern_sched.sv
// Write NUM_WORDS LFSR words, replay the sequence on readback, count mismatches.
module barcodescanner_nios_altmemddr_0_ex_pattern_sched
    import barcodescanner_nios_altmemddr_0_ex_pattern_sched_pkg::*;
#(
    parameter int SEED      = 32,
    parameter int NUM_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [LFSR_W-1:0] wr_data,
    input  logic              rd_valid,
    input  logic [LFSR_W-1:0] rd_data,
    output logic [ERR_W-1:0]  err_count
);

    localparam logic [LFSR_W-1:0] SEED8 = SEED[LFSR_W-1:0];
    localparam logic [7:0]        LAST  = 8'(NUM_WORDS - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pass_q, pass_d;
    logic              lfsr_en, lfsr_pause;
    logic [LFSR_W-1:0] lfsr_val;

    barcodescanner_nios_altmemddr_0_ex_lfsr8 #(.SEED(SEED8)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (lfsr_en),
        .pause   (lfsr_pause),
        .load    (1'b0),
        .ldata   ('0),
        .data    (lfsr_val)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pass_d     = pass_q;
        lfsr_en    = 1'b1;
        lfsr_pause = 1'b1;
        case (state_q)
            S_IDLE: begin
                // Holding enable low keeps the LFSR parked at SEED between runs.
                lfsr_en = 1'b0;
                if (start) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    lfsr_pause = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                    if (cnt_q == LAST) begin
                        state_d = S_RESEED;
                        cnt_d   = '0;
                    end
                end
            end
            S_RESEED: begin
                lfsr_en = 1'b0;
                state_d = S_READ;
                cnt_d   = '0;
            end
            S_READ: begin
                if (rd_valid) begin
                    lfsr_pause = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                    if (rd_data != lfsr_val)
                        err_d = sat_inc(err_q);
                    // Verdict includes the final beat so pass is valid alongside done.
                    if (cnt_q == LAST) begin
                        state_d = S_FINISH;
                        cnt_d   = '0;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign wr_req    = (state_q == S_WRITE);
    assign wr_data   = lfsr_val;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule
